// File: rtl/qam_pkg.sv
// Mode encodings and per-mode symbol geometry for the QAM stream mapper.
package qam_pkg;

  localparam int QAM_MODE_W = 3;

  typedef enum logic [QAM_MODE_W-1:0] {
    QAM_BPSK = 3'd0,
    QAM_QPSK = 3'd1,
    QAM_16   = 3'd2,
    QAM_64   = 3'd3,
    QAM_256  = 3'd4
  } qam_mode_e;

  function automatic logic [3:0] bits_per_sym(input qam_mode_e mode);
    case (mode)
      QAM_BPSK: return 4'd1;
      QAM_QPSK: return 4'd2;
      QAM_16:   return 4'd4;
      QAM_64:   return 4'd6;
      QAM_256:  return 4'd8;
      default:  return 4'd2;
    endcase
  endfunction

  // BPSK puts its single bit on I only, so it shares m=1 with QPSK.
  function automatic logic [2:0] axis_bits(input qam_mode_e mode);
    case (mode)
      QAM_BPSK: return 3'd1;
      QAM_QPSK: return 3'd1;
      QAM_16:   return 3'd2;
      QAM_64:   return 3'd3;
      QAM_256:  return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

  function automatic logic mode_legal(input logic [QAM_MODE_W-1:0] mode);
    return mode <= 3'd4;
  endfunction

endpackage

// File: rtl/qam_axis_level.sv
// Maps m axis bits to a scaled odd PAM level (2v - (2^m-1)) << (OUT_W-1-m).
// With GRAY_MAP_EN defined the axis bits are Gray-decoded before mapping.
module qam_axis_level
  import qam_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic [3:0]              bits,
  input  logic [2:0]              m,
  output logic signed [OUT_W-1:0] level
);

  logic [3:0]        mask;
  logic [3:0]        g;
  logic [3:0]        v;
  logic signed [5:0] a;
  int                shamt;

  always_comb begin
    mask = 4'((5'd1 << m) - 5'd1);
    g    = bits & mask;
`ifdef GRAY_MAP_EN
    // Bits above m are zero after masking, so a full 4-bit prefix XOR is exact.
    v[3] = g[3];
    v[2] = v[3] ^ g[2];
    v[1] = v[2] ^ g[1];
    v[0] = v[1] ^ g[0];
`else
    v = g;
`endif
    a     = $signed({1'b0, v, 1'b0}) - $signed({2'b00, mask});
    shamt = OUT_W - 1 - int'(m);
    level = {{(OUT_W-6){a[5]}}, a} <<< shamt;
  end

endmodule

// File: rtl/qam_stream_mapper.sv
// Repacks DATA_W-bit words MSB-first into BPSK..256QAM symbols and emits scaled I/Q.
// Optional build macro GRAY_MAP_EN selects Gray-coded axis mapping (see qam_axis_level).
module qam_stream_mapper
  import qam_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 12,
  parameter int BUF_W  = DATA_W + 7
) (
  input  logic                    dclk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [QAM_MODE_W-1:0]   mode,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CNT_W = $clog2(BUF_W + 1);

  // Valid bits sit left-justified in acc_q; everything below cnt is kept zero,
  // which makes the flush zero-padding free.
  logic [BUF_W-1:0]        acc_q;
  logic [BUF_W-1:0]        acc_shift;
  logic [BUF_W-1:0]        acc_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_after_pop;
  logic [CNT_W-1:0]        cnt_next;
  qam_mode_e               mode_q;
  logic [3:0]              k;
  logic [2:0]              m;
  logic [CNT_W-1:0]        k_ext;
  logic                    slot_free;
  logic                    pop_full;
  logic                    pop_flush;
  logic                    pop;
  logic                    accept;
  logic [7:0]              win;
  logic [7:0]              win_q;
  logic [3:0]              i_bits;
  logic [3:0]              q_bits;
  logic signed [OUT_W-1:0] lvl_i;
  logic signed [OUT_W-1:0] lvl_q;

  assign k     = bits_per_sym(mode_q);
  assign m     = axis_bits(mode_q);
  assign k_ext = CNT_W'(k);

  assign in_ready  = en && (cnt < k_ext);
  assign slot_free = !out_valid || out_ready;
  assign pop_full  = en && (cnt >= k_ext) && slot_free;
  assign pop_flush = en && flush && (cnt != '0) && (cnt < k_ext) && slot_free;
  assign pop       = pop_full || pop_flush;
  assign accept    = in_valid && in_ready;

  assign win    = acc_q[BUF_W-1 -: 8];
  assign win_q  = win << m;
  assign i_bits = win[7:4] >> (3'd4 - m);
  assign q_bits = win_q[7:4] >> (3'd4 - m);

  qam_axis_level #(.OUT_W(OUT_W)) u_level_i (.bits(i_bits), .m(m), .level(lvl_i));
  qam_axis_level #(.OUT_W(OUT_W)) u_level_q (.bits(q_bits), .m(m), .level(lvl_q));

  always_comb begin
    cnt_after_pop = cnt;
    acc_shift     = acc_q;
    if (pop_full) begin
      cnt_after_pop = cnt - k_ext;
      acc_shift     = acc_q << k;
    end else if (pop_flush) begin
      cnt_after_pop = '0;
      acc_shift     = '0;
    end
    acc_next = acc_shift;
    cnt_next = cnt_after_pop;
    if (accept) begin
      acc_next = acc_shift | ({in_data, {(BUF_W-DATA_W){1'b0}}} >> cnt_after_pop);
      cnt_next = cnt_after_pop + CNT_W'(DATA_W);
    end
  end

  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt       <= '0;
      mode_q    <= QAM_QPSK;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      acc_q <= acc_next;
      cnt   <= cnt_next;
      if (cnt == '0 && !out_valid && mode_legal(mode)) begin
        mode_q <= qam_mode_e'(mode);
      end
      if (pop) begin
        out_i     <= lvl_i;
        out_q     <= (mode_q == QAM_BPSK) ? '0 : lvl_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
